// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/mult_datapath.sv
// Operand capture, shift-add accumulator, bit counter and product register.
// All updates are gated by one-hot-style enables from the control FSM.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_ld_x,
    input  logic               i_ld_y,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_cap,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_cnt_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_cnt     <= '0;
        end else begin
            if (i_ld_x) r_x <= i_data;
            if (i_ld_y) r_y <= i_data;
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, r_x};
                r_mplier <= r_y;
                r_acc    <= '0;
                r_cnt    <= CW'(WIDTH);
            end else if (i_step) begin
                // Multiplicand shifts left so it stays aligned with the bit being examined.
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
            if (i_cap) r_product <= r_acc;
        end
    end

    assign o_product  = r_product;
    assign o_cnt_zero = (r_cnt == '0);
endmodule

// File: rtl/seq_multiplier.sv
// Control FSM for the shift-add multiplier: operand flags, busy and done pulse.
// go at edge k -> done and product change at edge k+WIDTH+1; loads/go ignored while busy.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   data,
    input  logic               load,
    input  logic               sel,
    input  logic               go,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               busy,
    output logic               loaded_x,
    output logic               loaded_y
);
    mult_state_t r_state;
    logic        r_done;
    logic        r_busy;
    logic        r_lx;
    logic        r_ly;

    logic w_idle;
    logic w_start;
    logic w_ld_x;
    logic w_ld_y;
    logic w_step;
    logic w_cap;
    logic w_cnt_zero;

    // A start takes priority over a same-cycle load.
    assign w_idle  = (r_state == IDLE);
    assign w_start = w_idle & go & r_lx & r_ly;
    assign w_ld_x  = w_idle & load & ~sel & ~w_start;
    assign w_ld_y  = w_idle & load &  sel & ~w_start;
    assign w_step  = (r_state == RUN) & ~w_cnt_zero;
    assign w_cap   = (r_state == RUN) &  w_cnt_zero;

    mult_datapath #(.WIDTH(WIDTH)) u_dp (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_data     (data),
        .i_ld_x     (w_ld_x),
        .i_ld_y     (w_ld_y),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_cap      (w_cap),
        .o_product  (product),
        .o_cnt_zero (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_lx    <= 1'b0;
            r_ly    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        if (w_ld_x) r_lx <= 1'b1;
                        if (w_ld_y) r_ly <= 1'b1;
                    end
                end
                RUN: begin
                    // Counter hits zero after WIDTH steps; the capture edge enters DONE.
                    if (w_cnt_zero) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_lx    <= 1'b0;
                    r_ly    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign busy     = r_busy;
    assign loaded_x = r_lx;
    assign loaded_y = r_ly;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier with a cycle-timed behavioural model.
module tb_seq_multiplier;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   data = '0;
    logic           load = 1'b0;
    logic           sel = 1'b0;
    logic           go = 1'b0;
    logic [2*W-1:0] product;
    logic           done;
    logic           busy;
    logic           loaded_x;
    logic           loaded_y;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    bit chk_en = 1'b0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .load     (load),
        .sel      (sel),
        .go       (go),
        .product  (product),
        .done     (done),
        .busy     (busy),
        .loaded_x (loaded_x),
        .loaded_y (loaded_y)
    );

    always #5 clk = ~clk;

    // Model: timeline measured in edges since the accepted go.
    bit           m_run = 0, m_lx = 0, m_ly = 0, m_done = 0, m_busy = 0;
    int           m_t = 0;
    logic [W-1:0] m_x = '0, m_y = '0;
    logic [2*W-1:0] m_prod = '0, m_pend = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_run = 0; m_lx = 0; m_ly = 0; m_done = 0; m_busy = 0;
            m_t = 0; m_x = '0; m_y = '0; m_prod = '0; m_pend = '0;
        end else if (!m_run) begin
            if (go && m_lx && m_ly) begin
                m_run = 1; m_t = 0; m_busy = 1;
                m_pend = (2*W)'(m_x) * (2*W)'(m_y);
            end else if (load) begin
                if (sel) begin m_y = data; m_ly = 1; end
                else     begin m_x = data; m_lx = 1; end
            end
        end else begin
            m_t++;
            if (m_t == W + 1) begin
                m_done = 1; m_prod = m_pend;
            end else if (m_t == W + 2) begin
                m_done = 0; m_busy = 0; m_lx = 0; m_ly = 0; m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({product, done, busy, loaded_x, loaded_y} !==
                {m_prod, m_done, m_busy, m_lx, m_ly}) begin
                errors++;
                $display("FAIL cycle t=%0t: got prod=%h done=%b busy=%b lx=%b ly=%b, want prod=%h done=%b busy=%b lx=%b ly=%b",
                         $time, product, done, busy, loaded_x, loaded_y,
                         m_prod, m_done, m_busy, m_lx, m_ly);
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load_op(input bit s, input logic [W-1:0] d);
        load = 1'b1; sel = s; data = d;
        tick();
        load = 1'b0;
    endtask

    task automatic run_op(input bit inject, output int lat);
        go = 1'b1;
        tick();
        go = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            if (inject) begin
                if (lat == 2) begin load = 1'b1; sel = 1'b0; data = 8'hAA; go = 1'b1; end
                if (lat == 3) begin sel = 1'b1; go = 1'b0; end
                if (lat == 5) begin load = 1'b0; go = 1'b1; end
                if (lat == 6) go = 1'b0;
            end
            tick();
            lat++;
        end
        load = 1'b0; go = 1'b0;
        if (lat >= 40) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 40 cycles, want done after 9");
        end
    endtask

    task automatic do_mult(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2*W-1:0] exp, input bit inject);
        int lat;
        int b0;
        load_op(1'b0, x);
        load_op(1'b1, y);
        b0 = busy_cnt;
        run_op(inject, lat);
        check({name, "_latency"}, 32'(lat), 32'd9);
        check({name, "_product"}, 32'(product), 32'(exp));
        check({name, "_model"}, 32'(m_prod), 32'(exp));
        tick();
        check({name, "_busy_cycles"}, 32'(busy_cnt - b0), 32'd10);
        check({name, "_flags_clear"}, {30'd0, loaded_x, loaded_y}, 32'd0);
    endtask

    initial begin
        int d0;
        int b0;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int b0;
        rst = 1'b0;
        repeat (2) tick();
        chk_en = 1'b1;
        check("reset_product", 32'(product), 32'd0);
        check("reset_done_busy", {30'd0, done, busy}, 32'd0);
        check("reset_flags", {30'd0, loaded_x, loaded_y}, 32'd0);
        rst = 1'b1;
        tick();

        // go with no operands loaded
        d0 = done_cnt; b0 = busy_cnt;
        go = 1'b1; tick(); go = 1'b0;
        repeat (20) tick();
        check("nogo_busy", 32'(busy_cnt - b0), 32'd0);
        check("nogo_done", 32'(done_cnt - d0), 32'd0);

        do_mult("basic_13x11", 8'd13, 8'd11, 16'h008F, 1'b0);
        do_mult("max_255x255", 8'd255, 8'd255, 16'hFE01, 1'b0);
        do_mult("zero_0x200", 8'd0, 8'd200, 16'h0000, 1'b0);
        do_mult("one_1x1", 8'd1, 8'd1, 16'h0001, 1'b0);
        do_mult("inject_9x7", 8'd9, 8'd7, 16'd63, 1'b1);

        // partial load: go with only X loaded is ignored
        b0 = busy_cnt;
        load_op(1'b0, 8'd5);
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        check("partial_busy", 32'(busy_cnt - b0), 32'd0);
        check("partial_lx", {31'd0, loaded_x}, 32'd1);
        do_mult("overwrite_7x6", 8'd7, 8'd6, 16'd42, 1'b0);

        // reset during the 4th RUN cycle
        load_op(1'b0, 8'd200);
        load_op(1'b1, 8'd3);
        go = 1'b1; tick(); go = 1'b0;
        repeat (3) tick();
        d0 = done_cnt;
        rst = 1'b0; tick(); rst = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (15) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_mult("after_abort_3x4", 8'd3, 8'd4, 16'd12, 1'b0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Downstream datapath for the multiply control FSM.
- Captures operands X and Y from a shared data bus. Reports loaded_x/loaded_y upstream, which uses loaded_x as the bus select.
- On go, runs an unsigned shift-add multiply over WIDTH cycles and pulses done, which the FSM uses as its stop/return condition.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- data  in  WIDTH  shared operand bus.
- load  in  1  operand capture strobe.
- sel  in  1  operand select: 0 = X, 1 = Y.
- go  in  1  start request, single-cycle pulse or level.
- product  out  2*WIDTH  registered result; holds until the next completion.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in RUN and DONE states.
- loaded_x  out  1  X register valid.
- loaded_y  out  1  Y register valid.

Behaviour:
- Reset: rst low at a rising edge forces, at that edge:
  - state = IDLE
  - product = 0, done = 0, busy = 0
  - loaded_x = 0, loaded_y = 0
  - X, Y, accumulator and counter = 0
- Reset mid-RUN aborts the operation; no done pulse is issued.
- States: IDLE, RUN, DONE, encoded as a 2-bit enum.
- IDLE:
  - load & !sel: X <= data, loaded_x <= 1.
  - load & sel: Y <= data, loaded_y <= 1.
  - Reloading an already-loaded operand overwrites it; the flag stays 1.
  - go & loaded_x & loaded_y: go to RUN.
    - Working multiplicand <= X, multiplier <= Y, accumulator <= 0, counter <= WIDTH.
    - load in the same cycle is ignored.
  - go without both flags set is ignored; remain in IDLE.
- RUN:
  - Each cycle: if multiplier[0] = 1, accumulator += multiplicand aligned at the current bit position. Multiplier shifts right 1, counter decrements.
  - Accumulator width is 2*WIDTH; no overflow is possible.
  - After exactly WIDTH RUN cycles (counter reaching 0), go to DONE.
  - There is no early termination on a zero multiplier; latency is fixed.
  - load and go are ignored throughout RUN.
- DONE, one cycle:
  - product <= accumulator, registered on entry so product and done change at the same edge.
  - done = 1.
  - Clears loaded_x and loaded_y at exit; new operands must be loaded before the next go.
  - Next state is IDLE.
  - load and go are ignored in DONE.
- Latency: go sampled at edge k gives done = 1 and the new product visible in the cycle after edge k+WIDTH+1. A new go is accepted no earlier than edge k+WIDTH+2, after a reload.
- busy is high from edge k through the end of the done cycle.
- done is never high for two consecutive cycles.
- The product register is not disturbed by loads or by an aborted run (reset excepted).

Decomposition:
- Package mult_pkg:
  - typedef enum logic [1:0] mult_state_t {IDLE, RUN, DONE}.
  - localparam DEFAULT_WIDTH = 8.
- Sub-module mult_datapath (X/Y capture registers, shift-add accumulator, bit counter):
  - Inputs: per-cycle enables from the top-level FSM.
  - Output: counter-zero flag.
- seq_multiplier instantiates mult_datapath and holds the FSM, done, busy and flags.

Test Plan:
- Reset then idle: rst = 0 for 2 cycles -> product = 0, done = 0, busy = 0, loaded_x = loaded_y = 0. Go with no operands -> no busy and no done for 20 cycles.
- Basic multiply: load X = 13 (sel = 0), load Y = 11 (sel = 1), go -> busy for 10 cycles. done is a single pulse 9 cycles after go is sampled, with product = 143 (0x008F). Flags clear after done.
- Extremes:
  - X = 255, Y = 255 -> product = 0xFE01.
  - X = 0, Y = 200 -> product = 0 with the same fixed latency.
  - X = 1, Y = 1 -> product = 1.
- Ignored inputs during RUN: load with data = 0xAA and go pulses issued mid-run -> the result still equals the original X*Y. loaded_x/loaded_y do not reflect the mid-run loads.
- Partial load / overwrite: load X = 5 only, then go -> ignored. Load X = 7, load Y = 6, go -> product = 42.
- Reset mid-RUN: assert rst = 0 on the 4th RUN cycle -> next cycle is IDLE, product = 0, done never pulses. A fresh run of 3*4 afterwards yields product = 12.
